// File: rtl/game_timer_bank.sv
// rtl/game_timer_bank.sv - bank of independent down-counting timers sharing one prescaler
// Each channel has start/stop/hold control and a one-shot or auto-reload mode.
module game_timer_bank #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] value,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       hold,
  input  logic [CHANNELS-1:0]       periodic,
  output logic [CHANNELS-1:0]       running,
  output logic [CHANNELS-1:0]       expired,
  output logic [CHANNELS*WIDTH-1:0] count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q  [CHANNELS];
  state_t              state_d  [CHANNELS];
  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    cnt_d    [CHANNELS];
  logic [WIDTH-1:0]    reload_q [CHANNELS];
  logic [WIDTH-1:0]    reload_d [CHANNELS];
  logic [CHANNELS-1:0] mode_q;
  logic [CHANNELS-1:0] mode_d;
  logic [CHANNELS-1:0] expired_q;
  logic [CHANNELS-1:0] expired_d;
  logic                tick;

  generate
    if (PRESCALE > 1) begin : g_prescale
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre_q;
      logic [PW-1:0] pre_d;

      always_comb begin
        pre_d = pre_q + PW'(1);
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
        end
      end

      assign tick = (pre_q == PRE_LAST);

      always_ff @(posedge clk) begin
        if (!reset) begin
          pre_q <= '0;
        end else begin
          pre_q <= pre_d;
        end
      end
    end else begin : g_no_prescale
      assign tick = 1'b1;
    end
  endgenerate

  // Priority per channel: start > stop > hold > tick; idle channels ignore all but start.
  always_comb begin
    mode_d    = mode_q;
    expired_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      reload_d[i] = reload_q[i];
      if (start[i]) begin
        state_d[i]  = ST_RUN;
        cnt_d[i]    = value[i*WIDTH +: WIDTH];
        reload_d[i] = value[i*WIDTH +: WIDTH];
        mode_d[i]   = periodic[i];
      end else if (stop[i]) begin
        state_d[i] = ST_IDLE;
      end else if (state_q[i] == ST_RUN && !hold[i] && tick) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end else begin
          expired_d[i] = 1'b1;
          if (mode_q[i]) begin
            cnt_d[i] = reload_q[i];
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q    <= '0;
      expired_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= ST_IDLE;
        cnt_q[i]    <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      mode_q    <= mode_d;
      expired_q <= expired_d;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]  <= state_d[i];
        cnt_q[i]    <= cnt_d[i];
        reload_q[i] <= reload_d[i];
      end
    end
  end

  always_comb begin
    running = '0;
    count   = '0;
    expired = expired_q;
    for (int i = 0; i < CHANNELS; i++) begin
      running[i]                = (state_q[i] == ST_RUN);
      count[i*WIDTH +: WIDTH]   = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_game_timer_bank.sv
// tb/tb_game_timer_bank.sv - directed bench for game_timer_bank (PRESCALE 1 and 4 instances)
module tb_game_timer_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value;
  logic [3:0]  start, stop, hold, periodic;
  logic [3:0]  running, expired;
  logic [31:0] count;

  logic [31:0] value_p;
  logic [3:0]  start_p, stop_p, hold_p, periodic_p;
  logic [3:0]  running_p, expired_p;
  logic [31:0] count_p;

  int total  = 0;
  int passes = 0;
  int n;
  logic seen;

  always #5 clk = ~clk;

  game_timer_bank #(.WIDTH(8), .CHANNELS(4), .PRESCALE(1)) dut (
    .clk(clk), .reset(reset), .value(value), .start(start), .stop(stop),
    .hold(hold), .periodic(periodic), .running(running), .expired(expired),
    .count(count)
  );

  game_timer_bank #(.WIDTH(8), .CHANNELS(4), .PRESCALE(4)) dut_p4 (
    .clk(clk), .reset(reset), .value(value_p), .start(start_p), .stop(stop_p),
    .hold(hold_p), .periodic(periodic_p), .running(running_p), .expired(expired_p),
    .count(count_p)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0; value = '0; start = '0; stop = '0; hold = '0; periodic = '0;
    value_p = '0; start_p = '0; stop_p = '0; hold_p = '0; periodic_p = '0;
    step(); step();
    check("rst_running", {28'd0, running}, 32'd0);
    check("rst_expired", {28'd0, expired}, 32'd0);
    check("rst_count", count, 32'd0);
    check("rst_running_p4", {28'd0, running_p}, 32'd0);
    reset = 1'b1;
    step();

    // one-shot ch0, value 5
    value[7:0] = 8'd5; start = 4'b0001;
    step();
    start = '0;
    check("os_load_count", {24'd0, count[7:0]}, 32'd5);
    check("os_load_run", {31'd0, running[0]}, 32'd1);
    for (int k = 4; k >= 0; k--) begin
      step();
      check("os_count", {24'd0, count[7:0]}, k);
      check("os_run", {31'd0, running[0]}, 32'd1);
      check("os_noexp", {31'd0, expired[0]}, 32'd0);
    end
    step();
    check("os_exp", {31'd0, expired[0]}, 32'd1);
    check("os_fall", {31'd0, running[0]}, 32'd0);
    check("os_count0", {24'd0, count[7:0]}, 32'd0);
    step();
    check("os_exp_single", {31'd0, expired[0]}, 32'd0);

    // idle ignores hold/stop
    stop = 4'b0001; hold = 4'b0001;
    step();
    stop = '0; hold = '0;
    check("idle_run", {31'd0, running[0]}, 32'd0);
    check("idle_exp", {31'd0, expired[0]}, 32'd0);

    // hold on ch2 for 7 cycles at count 6
    value[23:16] = 8'd10; start = 4'b0100;
    step();
    start = '0;
    check("hold_load", {24'd0, count[23:16]}, 32'd10);
    for (int k = 9; k >= 6; k--) begin
      step();
      check("hold_pre", {24'd0, count[23:16]}, k);
    end
    hold = 4'b0100;
    repeat (7) begin
      step();
      check("hold_frozen", {24'd0, count[23:16]}, 32'd6);
      check("hold_run", {31'd0, running[2]}, 32'd1);
      check("hold_noexp", {31'd0, expired[2]}, 32'd0);
    end
    hold = '0;
    for (int k = 5; k >= 0; k--) begin
      step();
      check("hold_post", {24'd0, count[23:16]}, k);
      check("hold_post_noexp", {31'd0, expired[2]}, 32'd0);
    end
    step();
    check("hold_exp", {31'd0, expired[2]}, 32'd1);
    check("hold_fall", {31'd0, running[2]}, 32'd0);

    // ch3: start beats stop, then zero load
    value[31:24] = 8'd3; start = 4'b1000; stop = 4'b1000;
    step();
    start = '0; stop = '0;
    check("ss_run", {31'd0, running[3]}, 32'd1);
    check("ss_count", {24'd0, count[31:24]}, 32'd3);
    value[31:24] = 8'd0; start = 4'b1000;
    step();
    start = '0;
    check("z_run", {31'd0, running[3]}, 32'd1);
    check("z_noexp", {31'd0, expired[3]}, 32'd0);
    step();
    check("z_exp", {31'd0, expired[3]}, 32'd1);
    check("z_fall", {31'd0, running[3]}, 32'd0);

    // periodic ch0 value 3, restart with 7 on the expiry tick
    value[7:0] = 8'd3; periodic = 4'b0001; start = 4'b0001;
    step();
    start = '0;
    for (int k = 2; k >= 0; k--) step();
    check("pr_at0", {24'd0, count[7:0]}, 32'd0);
    value[7:0] = 8'd7; start = 4'b0001;
    step();
    start = '0; periodic = '0;
    check("pr_suppress", {31'd0, expired[0]}, 32'd0);
    check("pr_newcount", {24'd0, count[7:0]}, 32'd7);
    for (int k = 6; k >= 0; k--) step();
    check("pr_at0b", {24'd0, count[7:0]}, 32'd0);
    step();
    check("pr_exp", {31'd0, expired[0]}, 32'd1);
    check("pr_reload7", {24'd0, count[7:0]}, 32'd7);
    check("pr_still_run", {31'd0, running[0]}, 32'd1);
    stop = 4'b0001;
    step();
    stop = '0;
    check("stop_run", {31'd0, running[0]}, 32'd0);
    check("stop_noexp", {31'd0, expired[0]}, 32'd0);
    check("stop_count", {24'd0, count[7:0]}, 32'd7);

    // PRESCALE=4 periodic ch1 value 2
    value_p[15:8] = 8'd2; periodic_p = 4'b0010; start_p = 4'b0010;
    step();
    start_p = '0; periodic_p = '0;
    check("p4_run", {31'd0, running_p[1]}, 32'd1);
    check("p4_load", {24'd0, count_p[15:8]}, 32'd2);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = expired_p[1];
    end
    check("p4_first_pulse", {31'd0, seen}, 32'd1);
    repeat (2) begin
      n = 0; seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        step();
        n++;
        seen = expired_p[1];
      end
      check("p4_interval", n, 32'd12);
      check("p4_reload", {24'd0, count_p[15:8]}, 32'd2);
      check("p4_run_kept", {31'd0, running_p[1]}, 32'd1);
    end
    stop_p = 4'b0010;
    step();
    stop_p = '0;
    check("p4_stop_run", {31'd0, running_p[1]}, 32'd0);
    check("p4_stop_noexp", {31'd0, expired_p[1]}, 32'd0);

    // all channels started, then reset mid-count
    value = {8'd3, 8'd2, 8'd1, 8'd0}; start = 4'b1111;
    step();
    start = '0;
    check("all_run", {28'd0, running}, 32'hf);
    check("all_count", count, 32'h03020100);
    step();
    check("all_exp0", {28'd0, expired}, 32'h1);
    check("all_run2", {28'd0, running}, 32'he);
    check("all_count2", count, 32'h02010000);
    reset = 1'b0;
    step();
    check("mr_run", {28'd0, running}, 32'd0);
    check("mr_exp", {28'd0, expired}, 32'd0);
    check("mr_count", count, 32'd0);
    reset = 1'b1;
    repeat (5) begin
      step();
      check("mr_quiet_exp", {28'd0, expired}, 32'd0);
      check("mr_quiet_run", {28'd0, running}, 32'd0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/game_timer_bank.md
GAME_TIMER_BANK -- requirements
Module: game_timer_bank

Interface
REQ-001 Parameter WIDTH, default 32: bit width of each channel counter and load value.
REQ-002 Parameter CHANNELS, default 4: number of independent timer channels (>=1).
REQ-003 Parameter PRESCALE, default 1: clock cycles per count tick (>=1; 1 = tick every cycle).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous reset, active-low: sampled on rising clk edge, asserted when 0.
REQ-006 value  input  CHANNELS*WIDTH  per-channel load value; channel i at bits [i*WIDTH +: WIDTH].
REQ-007 start  input  CHANNELS  per-channel load-and-run strobe.
REQ-008 stop  input  CHANNELS  per-channel abort strobe.
REQ-009 hold  input  CHANNELS  per-channel level; freezes the counter while high.
REQ-010 periodic  input  CHANNELS  per-channel mode, sampled at start: 1 = auto-reload, 0 = one-shot.
REQ-011 running  output  CHANNELS  channel is armed and counting (or held).
REQ-012 expired  output  CHANNELS  one-cycle pulse per channel expiry.
REQ-013 count  output  CHANNELS*WIDTH  current counter value per channel, same packing as value.

Function
REQ-014 Each channel SHALL be a two-state FSM, IDLE (running=0) and RUN (running=1), with a WIDTH-bit counter, a WIDTH-bit reload register and a mode bit.
REQ-015 A shared prescaler SHALL count 0..PRESCALE-1 freely while out of reset and assert internal tick in the cycle its value is PRESCALE-1; with PRESCALE=1 tick SHALL be constant 1.
REQ-016 start[i] SHALL, on the next edge, load counter and reload register from value_i, latch periodic[i], set running[i]=1; this applies in either state (restart).
REQ-017 Per-channel priority SHALL be start > stop > hold > count.
REQ-018 stop[i] without start[i] SHALL clear running[i] on the next edge, leave counter unchanged, and produce no expired pulse.
REQ-019 In RUN with hold[i]=1 (and no start/stop) the counter SHALL not change and expiry SHALL not occur; running stays 1.
REQ-020 In RUN, on a tick with hold[i]=0 and counter!=0, the counter SHALL decrement by 1.
REQ-021 In RUN, on a tick with hold[i]=0 and counter==0, expired[i] SHALL be 1 for exactly the following cycle; one-shot: running[i] clears on that same edge, counter stays 0; periodic: counter reloads from the reload register, running stays 1.
REQ-022 A one-shot start with value V and PRESCALE=1, no hold, SHALL keep running high for V+1 cycles and pulse expired in the cycle running first reads 0.
REQ-023 start with value 0 SHALL expire on the first tick after the load edge; periodic with reload 0 SHALL expire on every tick.
REQ-024 Counters SHALL never wrap below 0; no arithmetic underflow is permitted.
REQ-025 In IDLE, ticks, hold and stop SHALL have no effect; counter holds its last value.
REQ-026 start[i] coinciding with an expiry of channel i SHALL suppress that expired pulse and perform the load.
REQ-027 Channels SHALL be fully independent; any combination of simultaneous strobes across channels is legal.
REQ-028 Outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-029 While reset=0 at an edge: running=0, expired=0, all counters=0, reload registers=0, mode bits=0, prescaler=0; all inputs ignored.
REQ-030 Reset asserted mid-count SHALL abort all channels with no expired pulse; first edge with reset=1 resumes normal operation with the prescaler starting from 0.

Verification
REQ-031 PRESCALE=1, ch0 start value=5 one-shot -> running[0] high 6 cycles, count 5,4,3,2,1,0, expired[0] single pulse as running falls.
REQ-032 PRESCALE=4, ch1 start value=2 periodic -> expired[1] every 12 cycles, count reloads to 2, running stays 1 until stop[1]; stop -> running 0 next cycle, no pulse.
REQ-033 ch2 value=10, hold high for 7 cycles at count 6 -> count remains 6 throughout, expiry delayed exactly 7 cycles vs. no-hold run.
REQ-034 ch3 start and stop same cycle with value=3 -> start wins, running 1, count 3; start value=0 -> expired pulse one cycle after first tick.
REQ-035 All 4 channels started with values 0,1,2,3 simultaneously, reset=0 asserted at cycle 2 -> all outputs 0 next edge, no further pulses.
REQ-036 ch0 periodic value=3, start[0] asserted with value=7 on the expiry tick -> no expired pulse, count 7, new reload 7.
